// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: frame-latched digits, leading-zero
// suppression and 16-level PWM dimming on active-low an/seg/dp pins.
module seg_scan_display #(
  parameter int DIGITS    = 4,
  parameter int DIVIDE_BY = 100000
) (
  input  logic                  clk,
  input  logic                  btnC,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  input  logic [3:0]            brightness,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int PW = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Cathode patterns {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] font(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // A digit is suppressed while every digit from it up to the top is blank
  // or a plain zero without a decimal point; digit 0 always survives.
  function automatic logic [DIGITS-1:0] effectiveBlank(
    input logic [4*DIGITS-1:0] v,
    input logic [DIGITS-1:0]   b,
    input logic [DIGITS-1:0]   d,
    input logic                lz
  );
    logic [DIGITS-1:0] r;
    logic              chain;
    r     = b;
    chain = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      chain = chain & (b[k] | ((v[4*k +: 4] == 4'h0) & ~d[k]));
      r[k]  = r[k] | (lz & chain);
    end
    return r;
  endfunction

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic                pending;
  logic [4*DIGITS-1:0] nibBuf;
  logic [DIGITS-1:0]   darkBuf;
  logic [DIGITS-1:0]   dpBuf;

  logic                tick;
  logic                lastDigit;
  logic                capture;
  logic [3:0]          pLow;
  logic [3:0]          curNib;
  logic                slotOn;
  logic [DIGITS-1:0]   anNext;
  logic [6:0]          segNext;
  logic                dpNext;

  assign tick      = (presc == PW'(DIVIDE_BY - 1));
  assign lastDigit = (idx == IW'(DIGITS - 1));
  assign capture   = pending | (tick & lastDigit);
  assign pLow      = 4'(presc);

  always_comb begin
    anNext  = '1;
    segNext = '1;
    dpNext  = 1'b1;
    curNib  = nibBuf[{idx, 2'b00} +: 4];
    slotOn  = (pLow <= brightness) && !darkBuf[idx];
    if (slotOn) begin
      anNext  = ~(DIGITS'(1) << idx);
      segNext = font(curNib);
      dpNext  = ~dpBuf[idx];
    end
  end

  // Scan control, frame masks and registered pin drivers.
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      presc       <= '0;
      idx         <= '0;
      pending     <= 1'b1;
      darkBuf     <= '1;
      dpBuf       <= '0;
      an          <= '1;
      seg         <= '1;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (tick) begin
        presc <= '0;
        idx   <= lastDigit ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      if (capture) begin
        pending <= 1'b0;
        darkBuf <= effectiveBlank(value, blank, dp_in, lz_en);
        dpBuf   <= dp_in;
      end
      an          <= anNext;
      seg         <= segNext;
      dp          <= dpNext;
      frame_start <= capture;
    end
  end

  // Digit values need no reset: the dark mask hides them until first capture.
  always_ff @(posedge clk) begin
    if (capture) nibBuf <= value;
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment scanner, the successor to the fixed 4-digit calculator display path. It drives DIGITS active-low anodes and a shared active-low cathode bus. The value, blank and decimal-point inputs are latched once per frame, so the display never tears; leading-zero suppression and 16-level PWM brightness are added. It sits between datapath results and the board's an/seg/dp pins.

## Interface
- DIGITS, 4, number of digits (1..8); digit 0 is rightmost, drives an[0]
- DIVIDE_BY, 100000, clocks per digit dwell slot (>=1)
- clk  in  1  system clock, all state on rising edge
- btnC  in  1  reset, asynchronous, active-high
- value  in  4*DIGITS  nibble k = value[4k+3:4k] = hex digit k
- blank  in  DIGITS  1 = digit k dark
- dp_in  in  DIGITS  1 = decimal point of digit k lit
- lz_en  in  1  leading-zero suppression enable
- brightness  in  4  on-time level, 15 = full
- an  out  DIGITS  anodes, active-low, at most one low
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_start  out  1  one-cycle pulse after each frame capture

## Operation
- Prescaler p counts 0..DIVIDE_BY-1. tick = (p == DIVIDE_BY-1). On tick, p goes to 0 and idx goes to idx+1, wrapping DIGITS-1 to 0.
- Slot enable: en = (p mod 16) <= brightness. brightness=15 gives always on; with DIVIDE_BY=1 the enable is always 1.
- Frame buffer holds nibbles, an effective-blank mask and a dp mask.
- Capture occurs on the edge where pending=1 (set by reset), or on the edge where tick && idx==DIGITS-1. The capture samples value, blank, dp_in and lz_en, and clears pending.
- Leading-zero suppression, applied at capture when lz_en=1: digit k (k>=1) is effectively blanked if, for every j>=k, either blank[j]=1 or (nibble j == 0 and dp_in[j]=0). Digit 0 is never suppressed.
- Output register, every edge, uses pre-edge idx, p and buffer:
  - If en and the digit is not effectively blanked: an = ~(1<<idx), seg = font(nibble idx), dp = ~dpbuf[idx].
  - Otherwise: an, seg and dp are all ones.
- Font (hex): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- brightness is used live and is not latched. Changes to value, blank, dp_in or lz_en mid-frame are invisible until the next capture.

## Timing
- Reset (asynchronous, immediate):
  - an, seg and dp all ones; frame_start=0.
  - idx=0, p=0, pending=1.
  - Buffer fully blanked.
- Reset mid-scan aborts the frame immediately. After release it behaves identically to power-up.
- First edge after release (E1): capture. Outputs dark, because the buffer was blank pre-edge.
- frame_start is high for exactly the cycle following each capture edge, including after E1.
- Output latency: outputs after edge k reflect the idx/p state held before edge k. This is a 1-cycle registered lag with no combinational input-to-output path.
- Dwell: each digit is selected for exactly DIVIDE_BY cycles, so a frame is DIGITS*DIVIDE_BY cycles. Captures are spaced by exactly that, apart from the first.
- DIGITS=1: idx stays 0 and a capture occurs on every tick.
- Anode invariant: never more than one an bit low in any cycle.

## Test plan
- Reset-scan: DIGITS=4, DIVIDE_BY=1, brightness=15, value=16'hA521, blank=0, dp_in=0, lz_en=0. Expected:
  - After E1 all dark and frame_start=1.
  - Then cycling an=1101/1011/0111/1110 with seg=0100100 ('2'), 0010010 ('5'), 0001000 ('A'), 1111001 ('1').
  - frame_start re-pulses every 4 cycles.
- No-tear: change value to 16'hFFFF while idx=2. Digits 2 and 3 still show '5' and 'A'. The next frame shows 'F' (0001110) on all four digits.
- Leading zeros: value=16'h0070, lz_en=1. Expected:
  - Digits 3 and 2 dark; digit 1 = '7', digit 0 = '0'.
  - With dp_in=4'b1000, digit 3 lights '0' with dp=0, and suppression stops at digit 3, so digit 2 shows '0'.
- PWM: DIVIDE_BY=32, brightness=3. Each digit slot shows the anode low for p mod 16 in 0..3, i.e. 8 of 32 cycles. brightness=15 gives a 32-of-32 duty.
- Blank: blank=4'b0101 → an[0] and an[2] never low; dp_in on a blanked digit never lit.
- Async reset mid-frame: assert btnC between edges. Expected:
  - an=1111, seg=1111111, dp=1 and frame_start=0 immediately, with no clock needed.
  - After release, the sequence restarts exactly as in the reset-scan case.
